capture_controller: RTL and testbench
=====================================

# capture_controller

Sequencer for the analyzer's circular sample buffer and its write address controller. Arms a capture, clears and enables write addressing, detects the trigger, counts a programmable number of post-trigger samples, then stops writing. It then replays buffer read addresses oldest-first over a valid/ready handshake. Sits between the host/trigger logic and the write address controller plus sample memory.

## Interface
- ADDR_WIDTH, default `ADDR_WIDTH (from define.v): buffer address width; depth = 2^ADDR_WIDTH.
- clk  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- arm  in  1  start a capture; accepted in IDLE or DONE.
- abort  in  1  return to IDLE from any state; overrides every other input.
- trigger  in  1  trigger qualifier; sampled in ARMED only.
- post_count  in  ADDR_WIDTH  samples written after the trigger sample; sampled on the trigger cycle.
- waddr  in  ADDR_WIDTH  current write address from the write address controller.
- primed  in  1  buffer-wrapped flag from the write address controller.
- wac_clear  out  1  active-high one-cycle clear to the write address controller.
- write_enable  out  1  write enable to the write address controller and memory.
- triggered  out  1  trigger accepted in the current capture.
- done  out  1  capture complete; high in DONE.
- trig_addr  out  ADDR_WIDTH  address of the trigger sample.
- rd_start  in  1  begin readout; accepted in DONE only.
- rd_addr  out  ADDR_WIDTH  read address.
- rd_valid  out  1  rd_addr is valid.
- rd_ready  in  1  consumer accepts rd_addr.
- rd_last  out  1  qualifies the final read address.

## Operation
- States: IDLE, ARMED, POST, DONE, READ.
- Reset values: state IDLE; every output 0, including trig_addr.
- IDLE/DONE, arm=1: go to ARMED. wac_clear=1 for the cycle spent in the transition edge's next cycle; triggered cleared.
- ARMED: write_enable=1.
  - If trigger=1: trig_addr<=waddr, triggered<=1, cnt<=post_count.
  - post_count=0: go to DONE. Otherwise go to POST.
- POST: write_enable=1 each cycle; cnt decrements. When cnt==1, go to DONE.
- Result: exactly post_count+1 writes from the trigger cycle onward, the trigger sample included.
- DONE: write_enable=0, done=1. rd_start=1 captures the readout window and goes to READ; arm takes priority over rd_start.
- Readout window:
  - primed=1: start=waddr, length=2^ADDR_WIDTH.
  - primed=0: start=0, length=waddr.
  - Length counter is ADDR_WIDTH+1 bits.
- READ: rd_valid=1 and rd_addr=current address.
  - On rd_valid&&rd_ready: address increments modulo 2^ADDR_WIDTH and remaining decrements.
  - rd_last=1 when remaining==1.
  - Handshake with rd_last: go to IDLE; rd_valid drops the next cycle.
  - rd_addr holds while rd_ready=0.
- abort: next state IDLE. write_enable, rd_valid and done drop the next cycle. triggered and trig_addr are retained.
- reset low mid-operation: all state and outputs take reset values at the next edge.
- trigger outside ARMED, and arm in ARMED/POST/READ: ignored.

## Timing
- write_enable, done, rd_valid and rd_last are decoded from registered state; no input-to-output combinational path.
- arm at edge k: ARMED from edge k+1, wac_clear high k+1..k+2. The first write is seen with waddr=0 one cycle later.
- Trigger at cycle t writes at t. The last write is at t+post_count. done is high from t+post_count+1.
- waddr and primed are final on DONE entry, because the write address controller updates on the same edge.
- READ: one address per cycle at rd_ready=1. rd_start to first rd_valid is 1 cycle.

## Configuration
- CAPTURE_TRIG_WAIT_PRIMED_EN defined: trigger in ARMED is ignored until primed=1, guaranteeing a full pre-trigger history. Readout then always uses the primed window.
- Macro undefined: trigger is accepted on any ARMED cycle, including before the buffer has wrapped.

## Structure
- Shared package capture_pkg holds:
  - State encoding localparams (IDLE=0, ARMED=1, POST=2, DONE=3, READ=4; 3-bit).
  - Readout length width ADDR_WIDTH+1.
- ADDR_WIDTH stays in define.v.
- One sub-module: capture_readout. It owns the start/length registers, rd_addr, remaining and rd_last, with start/busy/last_done strobes to the main FSM.

## Test plan
All scenarios use ADDR_WIDTH=4 with a write address controller model attached.
- reset low 2 cycles, then arm: wac_clear is high 1 cycle, write_enable rises next cycle, and waddr counts 0,1,2…
- arm, trigger when waddr=5, post_count=3: trig_addr=5, writes at 5..8, done with waddr=9, primed=0. Readout gives 0..8 with rd_last on 8.
- arm, run 20 cycles, trigger at waddr=4, post_count=15: primed=1. Readout starts at 4 (final waddr), gives 16 addresses 4..15,0..3, rd_last on 3.
- post_count=0, trigger on the first ARMED cycle: exactly one write, done next cycle.
- abort during POST: write_enable low next cycle, state IDLE, done=0, and a later rd_start produces no rd_valid.
- READ with rd_ready toggling 1,0,0,1: rd_addr holds through the stalls and no address is skipped or duplicated.
- CAPTURE_TRIG_WAIT_PRIMED_EN defined, trigger held high from arm: trig_addr=0, captured on the first cycle with primed=1.

Source files
------------

// File: rtl/capture_pkg.sv
// capture_pkg: state encoding and widths shared by the capture sequencer and
// its readout unit. ADDR_WIDTH normally comes from define.v; a fallback of 4
// applies when that file is not in the build.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif

package capture_pkg;

    localparam int AW    = `ADDR_WIDTH;
    // The readout length must hold a full 2^AW window, hence one extra bit.
    localparam int LEN_W = AW + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        POST  = 3'd2,
        DONE  = 3'd3,
        READ  = 3'd4
    } state_t;

endpackage

// File: rtl/capture_readout.sv
// capture_readout: replays the circular buffer oldest-first over a
// valid/ready handshake. Loads its window on start, drops out on abort.
// Optional macro CAPTURE_TRIG_WAIT_PRIMED_EN forces the wrapped window.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif

module capture_readout #(
    parameter int ADDR_WIDTH = `ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic                  primed,
    input  logic                  rd_ready,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_valid,
    output logic                  rd_last,
    output logic                  busy,
    output logic                  last_done
);

    localparam int LW = ADDR_WIDTH + 1;

    logic [LW-1:0]         remaining;
    logic [LW-1:0]         win_len;
    logic [ADDR_WIDTH-1:0] win_start;
    logic                  use_full;

    // Window selection: a wrapped buffer starts at the oldest sample (waddr).
    always_comb begin
`ifdef CAPTURE_TRIG_WAIT_PRIMED_EN
        use_full = 1'b1;
`else
        use_full = primed;
`endif
        win_len   = '0;
        win_start = '0;
        if (use_full) begin
            win_start          = waddr;
            win_len[ADDR_WIDTH] = 1'b1;
        end else begin
            win_len[ADDR_WIDTH-1:0] = waddr;
        end
    end

    assign busy      = rd_valid;
    assign last_done = rd_valid && rd_ready && rd_last;

    // Address/remaining registers advance only on an accepted handshake.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_addr   <= '0;
            remaining <= '0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
        end else if (abort) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
        end else if (start) begin
            rd_addr   <= win_start;
            remaining <= win_len;
            rd_valid  <= (win_len != '0);
            rd_last   <= (win_len == LW'(1));
        end else if (rd_valid && rd_ready) begin
            if (rd_last) begin
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
            end else begin
                rd_addr   <= rd_addr + 1'b1;
                remaining <= remaining - 1'b1;
                rd_last   <= (remaining == LW'(2));
            end
        end
    end

endmodule

// File: rtl/capture_controller.sv
// capture_controller: arms a capture, enables buffer writes, latches the
// trigger address, counts post-trigger samples and hands off to readout.
// Optional macro CAPTURE_TRIG_WAIT_PRIMED_EN: trigger waits for primed=1.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif

module capture_controller
    import capture_pkg::*;
#(
    parameter int ADDR_WIDTH = `ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  trigger,
    input  logic [ADDR_WIDTH-1:0] post_count,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic                  primed,
    output logic                  wac_clear,
    output logic                  write_enable,
    output logic                  triggered,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    input  logic                  rd_start,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_last
);

    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  trig_ok;
    logic                  rd_go;
    logic                  rd_busy;
    logic                  rd_last_done;

    // A trigger only counts on a cycle that actually writes, so the trigger
    // sample is always in the buffer.
    always_comb begin
`ifdef CAPTURE_TRIG_WAIT_PRIMED_EN
        trig_ok = trigger && write_enable && primed;
`else
        trig_ok = trigger && write_enable;
`endif
    end

    assign rd_go = (state == DONE) && rd_start && !arm && !abort;

    // Capture sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            wac_clear    <= 1'b0;
            write_enable <= 1'b0;
            triggered    <= 1'b0;
            done         <= 1'b0;
            trig_addr    <= '0;
        end else begin
            wac_clear <= 1'b0;
            if (abort) begin
                state        <= IDLE;
                write_enable <= 1'b0;
                done         <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (arm) begin
                            state     <= ARMED;
                            wac_clear <= 1'b1;
                            triggered <= 1'b0;
                        end
                    end
                    ARMED: begin
                        // First ARMED cycle is the clear cycle; writes start after it.
                        write_enable <= 1'b1;
                        if (trig_ok) begin
                            trig_addr <= waddr;
                            triggered <= 1'b1;
                            cnt       <= post_count;
                            if (post_count == '0) begin
                                state        <= DONE;
                                write_enable <= 1'b0;
                                done         <= 1'b1;
                            end else begin
                                state <= POST;
                            end
                        end
                    end
                    POST: begin
                        cnt <= cnt - 1'b1;
                        if (cnt == ADDR_WIDTH'(1)) begin
                            state        <= DONE;
                            write_enable <= 1'b0;
                            done         <= 1'b1;
                        end
                    end
                    DONE: begin
                        if (arm) begin
                            state     <= ARMED;
                            wac_clear <= 1'b1;
                            triggered <= 1'b0;
                            done      <= 1'b0;
                        end else if (rd_start) begin
                            state <= READ;
                            done  <= 1'b0;
                        end
                    end
                    READ: begin
                        if (rd_last_done || !rd_busy) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    capture_readout #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_readout (
        .clk      (clk),
        .reset    (reset),
        .start    (rd_go),
        .abort    (abort),
        .waddr    (waddr),
        .primed   (primed),
        .rd_ready (rd_ready),
        .rd_addr  (rd_addr),
        .rd_valid (rd_valid),
        .rd_last  (rd_last),
        .busy     (rd_busy),
        .last_done(rd_last_done)
    );

endmodule

// File: tb/tb_capture_controller.sv
// tb_capture_controller: directed bench with a write address controller
// model, ADDR_WIDTH=4.
module tb_capture_controller;

    logic       clk;
    logic       reset;
    logic       arm;
    logic       abort;
    logic       trigger;
    logic [3:0] post_count;
    logic [3:0] waddr;
    logic       primed;
    logic       wac_clear;
    logic       write_enable;
    logic       triggered;
    logic       done;
    logic [3:0] trig_addr;
    logic       rd_start;
    logic [3:0] rd_addr;
    logic       rd_valid;
    logic       rd_ready;
    logic       rd_last;

    int n_checks = 0;
    int n_fail   = 0;

    capture_controller #(.ADDR_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .arm(arm), .abort(abort), .trigger(trigger),
        .post_count(post_count), .waddr(waddr), .primed(primed),
        .wac_clear(wac_clear), .write_enable(write_enable), .triggered(triggered),
        .done(done), .trig_addr(trig_addr), .rd_start(rd_start), .rd_addr(rd_addr),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write address controller model: clear, count on write, flag the wrap.
    always_ff @(posedge clk) begin
        if (!reset || wac_clear) begin
            waddr  <= 4'd0;
            primed <= 1'b0;
        end else if (write_enable) begin
            waddr <= waddr + 4'd1;
            if (waddr == 4'd15) primed <= 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Arm and advance to the first writing cycle (waddr=0).
    task automatic start_capture();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        tick();
    endtask

    initial begin
        logic       rdy_pat  [6];
        logic [3:0] addr_pat [6];
        logic       last_pat [6];
        int         guard;

        reset = 1'b0; arm = 1'b0; abort = 1'b0; trigger = 1'b0;
        post_count = 4'd0; rd_start = 1'b0; rd_ready = 1'b0;
        tick();
        tick();

        // Reset values
        check1("rst_we", write_enable, 1'b0);
        check1("rst_clr", wac_clear, 1'b0);
        check1("rst_trig", triggered, 1'b0);
        check1("rst_done", done, 1'b0);
        check4("rst_taddr", trig_addr, 4'd0);
        check1("rst_rvalid", rd_valid, 1'b0);
        check1("rst_rlast", rd_last, 1'b0);
        check4("rst_raddr", rd_addr, 4'd0);
        check3("rst_state", dut.state, 3'd0);

        // Trigger in IDLE is ignored
        reset = 1'b1;
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        check1("idle_trig_ignored", triggered, 1'b0);

        // Arm: one-cycle clear, then writes from waddr=0
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check1("arm_clr_hi", wac_clear, 1'b1);
        check1("arm_we_lo", write_enable, 1'b0);
        check3("arm_state", dut.state, 3'd1);
        tick();
        check1("arm_clr_lo", wac_clear, 1'b0);
        check1("arm_we_hi", write_enable, 1'b1);
        check4("arm_waddr0", waddr, 4'd0);
        tick();
        check4("arm_waddr1", waddr, 4'd1);
        tick();
        check4("arm_waddr2", waddr, 4'd2);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check1("arm_in_armed_no_clr", wac_clear, 1'b0);
        check4("arm_waddr3", waddr, 4'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check1("abort_armed_we", write_enable, 1'b0);
        check3("abort_armed_state", dut.state, 3'd0);

        // Trigger at waddr=5, post_count=3, then read 0..8
        start_capture();
        repeat (5) tick();
        check4("t2_waddr5", waddr, 4'd5);
        trigger = 1'b1;
        post_count = 4'd3;
        tick();
        trigger = 1'b0;
        check1("t2_triggered", triggered, 1'b1);
        check4("t2_taddr", trig_addr, 4'd5);
        check1("t2_we_post", write_enable, 1'b1);
        repeat (3) tick();
        check1("t2_done", done, 1'b1);
        check1("t2_we_off", write_enable, 1'b0);
        check4("t2_waddr_final", waddr, 4'd9);
        check1("t2_primed", primed, 1'b0);
        tick();
        check1("t2_done_hold", done, 1'b1);
        rd_start = 1'b1;
        rd_ready = 1'b1;
        tick();
        rd_start = 1'b0;
        check1("t2_done_drop", done, 1'b0);
        for (int i = 0; i < 9; i++) begin
            check1("t2_rvalid", rd_valid, 1'b1);
            check4("t2_raddr", rd_addr, 4'(i));
            check1("t2_rlast", rd_last, (i == 8));
            tick();
        end
        check1("t2_rvalid_end", rd_valid, 1'b0);
        check3("t2_state_end", dut.state, 3'd0);

        // Wrapped buffer: trigger at waddr=4 after 20 cycles, post_count=15
        start_capture();
        repeat (20) tick();
        check4("t3_waddr4", waddr, 4'd4);
        check1("t3_primed", primed, 1'b1);
        trigger = 1'b1;
        post_count = 4'd15;
        tick();
        trigger = 1'b0;
        check4("t3_taddr", trig_addr, 4'd4);
        repeat (14) tick();
        check1("t3_not_done_yet", done, 1'b0);
        tick();
        check1("t3_done", done, 1'b1);
        check4("t3_waddr_final", waddr, 4'd4);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check1("t3_rvalid", rd_valid, 1'b1);
            check4("t3_raddr", rd_addr, 4'((i + 4) % 16));
            check1("t3_rlast", rd_last, (i == 15));
            tick();
        end
        check1("t3_rvalid_end", rd_valid, 1'b0);

        // post_count=0 on the first writing cycle: exactly one write
        start_capture();
        trigger = 1'b1;
        post_count = 4'd0;
        tick();
        trigger = 1'b0;
        check1("t4_done", done, 1'b1);
        check1("t4_we", write_enable, 1'b0);
        check4("t4_waddr", waddr, 4'd1);
        check4("t4_taddr", trig_addr, 4'd0);

        // Abort during POST (arm accepted from DONE)
        start_capture();
        repeat (2) tick();
        trigger = 1'b1;
        post_count = 4'd10;
        tick();
        trigger = 1'b0;
        tick();
        check3("t5_in_post", dut.state, 3'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check1("t5_we", write_enable, 1'b0);
        check3("t5_state", dut.state, 3'd0);
        check1("t5_done", done, 1'b0);
        check1("t5_trig_kept", triggered, 1'b1);
        check4("t5_taddr_kept", trig_addr, 4'd2);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        check1("t5_no_rvalid", rd_valid, 1'b0);
        tick();
        check1("t5_no_rvalid2", rd_valid, 1'b0);

        // Readout with stalls: capture writes 1..3, read 0..3
        start_capture();
        tick();
        trigger = 1'b1;
        post_count = 4'd2;
        tick();
        trigger = 1'b0;
        repeat (2) tick();
        check1("t6_done", done, 1'b1);
        check4("t6_waddr", waddr, 4'd4);
        rd_ready = 1'b0;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        rdy_pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        addr_pat = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd3};
        last_pat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            rd_ready = rdy_pat[i];
            check1("t6_rvalid", rd_valid, 1'b1);
            check4("t6_raddr", rd_addr, addr_pat[i]);
            check1("t6_rlast", rd_last, last_pat[i]);
            tick();
        end
        check1("t6_rvalid_end", rd_valid, 1'b0);

`ifdef CAPTURE_TRIG_WAIT_PRIMED_EN
        // Trigger held from arm is taken on the first primed cycle
        trigger = 1'b1;
        post_count = 4'd0;
        start_capture();
        guard = 0;
        while (!triggered && guard < 40) begin
            tick();
            guard++;
        end
        trigger = 1'b0;
        check1("t7_triggered", triggered, 1'b1);
        check4("t7_taddr", trig_addr, 4'd0);
        check1("t7_primed", primed, 1'b1);
`else
        guard = 0;
`endif

        // Reset low mid-capture
        start_capture();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check1("t8_we", write_enable, 1'b0);
        check3("t8_state", dut.state, 3'd0);
        check1("t8_clr", wac_clear, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
